irq_seq: RTL and testbench

- Parametrised vectored interrupt/exception entry sequencer, the successor to the control unit's fixed single-IRQ entry path.
- The control unit hands off at an instruction boundary. This block then drives the datapath through three steps: push PC, push STATUS, load PC with a vector.
- It adds NUM_IRQ prioritised channels, a per-channel enable mask, per-channel edge/level capture, round-robin or fixed priority, and per-channel vectors.

---
 rtl/irq_seq.sv | 200 ++++++++++++++++++++
 tb/tb_irq_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_seq.sv
// irq_seq_pkg: shared datapath encodings (processor mode, register-select codes).
// irq_seq: vectored interrupt/exception entry sequencer.
//   After the control unit pulses start at an instruction boundary, the block
//   walks the datapath through push PC, push STATUS, load PC from a vector.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     en                      global enable; low freezes state and zeroes strobes
//     irq[NUM_IRQ]            request lines (per-channel edge or level capture)
//     mask_wr, mask_in        channel enable mask load
//     imask                   global interrupt enable (STATUS.imask)
//     start, swint, except    entry request and cause qualifiers
//     hw_pending, busy, done  status
//     pre_dec_sp, wr, oe_a_reg, oe_b_reg, sel_a_reg, sel_b_reg   stack pushes
//     ld_imask, imask_in, ld_mode, mode_in                       STATUS updates
//     vec_out, oe_vec, ld_pc                                     vector load
//     ack[NUM_IRQ], irq_id    acknowledge and id of last serviced hw channel
package irq_seq_pkg;
  typedef enum logic [1:0] {MODE_USER = 2'd0, MODE_SUPERVISOR = 2'd1} cpu_mode_e;
  localparam logic [3:0] REG_SP     = 4'hD;
  localparam logic [3:0] REG_STATUS = 4'hE;
  localparam logic [3:0] REG_PC     = 4'hF;
endpackage

module irq_seq
  import irq_seq_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter bit          RR_EN       = 1'b0,
  parameter logic [31:0] VEC_SW      = 32'h2,
  parameter logic [31:0] VEC_EXC     = 32'h3,
  parameter logic [31:0] VEC_HW_BASE = 32'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               imask,
  input  logic               start,
  input  logic               swint,
  input  logic               except,
  output logic               hw_pending,
  output logic               busy,
  output logic               done,
  output logic               pre_dec_sp,
  output logic               wr,
  output logic               oe_a_reg,
  output logic               oe_b_reg,
  output logic [3:0]         sel_a_reg,
  output logic [3:0]         sel_b_reg,
  output logic               ld_imask,
  output logic               imask_in,
  output logic               ld_mode,
  output cpu_mode_e          mode_in,
  output logic [31:0]        vec_out,
  output logic               oe_vec,
  output logic               ld_pc,
  output logic [NUM_IRQ-1:0] ack,
  output logic [4:0]         irq_id
);

  typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_ST, LOAD_VEC, DONE} state_e;
  typedef enum logic [1:0] {CAUSE_HW, CAUSE_SW, CAUSE_EXC} cause_e;

  state_e             state_q, state_d;
  cause_e             cause_q;
  logic [NUM_IRQ-1:0] mask_q, pend_q, irq_prev_q, cand;
  logic [4:0]         id_q, rr_ptr_q, win_id;
  logic               found;
  logic [31:0]        vec;

  assign cand       = pend_q & mask_q;
  assign hw_pending = imask & (|cand);
  assign busy       = (state_q != IDLE);

  // Winner search starts at rr_ptr in round-robin mode, at 0 otherwise;
  // the index wraps once so every channel is visited exactly once.
  always_comb begin : pick
    int idx;
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = k + (RR_EN ? int'(rr_ptr_q) : 0);
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        win_id = 5'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start && (except || swint || hw_pending)) state_d = PUSH_PC;
      PUSH_PC:  state_d = PUSH_ST;
      PUSH_ST:  state_d = LOAD_VEC;
      LOAD_VEC: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      pend_q     <= '0;
      irq_prev_q <= '0;
      cause_q    <= CAUSE_HW;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      irq_id     <= '0;
    end else if (en) begin
      if (mask_wr) mask_q <= mask_in;
      irq_prev_q <= irq;
      // A fresh edge wins over a same-cycle ack so that request is not lost.
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (EDGE_MASK[i]) pend_q[i] <= (irq[i] & ~irq_prev_q[i]) | (pend_q[i] & ~ack[i]);
        else              pend_q[i] <= irq[i];
      end
      if (state_q == IDLE && start) begin
        if (except)     cause_q <= CAUSE_EXC;
        else if (swint) cause_q <= CAUSE_SW;
        else if (hw_pending) begin
          cause_q <= CAUSE_HW;
          id_q    <= win_id;
        end
      end
      if (state_q == LOAD_VEC && cause_q == CAUSE_HW) begin
        irq_id <= id_q;
        if (RR_EN) rr_ptr_q <= (id_q == 5'(NUM_IRQ - 1)) ? 5'd0 : id_q + 5'd1;
      end
    end
  end

  always_comb begin
    case (cause_q)
      CAUSE_EXC: vec = VEC_EXC;
      CAUSE_SW:  vec = VEC_SW;
      default:   vec = VEC_HW_BASE + {27'b0, id_q};
    endcase
  end

  always_comb begin
    done       = 1'b0;
    pre_dec_sp = 1'b0;
    wr         = 1'b0;
    oe_a_reg   = 1'b0;
    oe_b_reg   = 1'b0;
    sel_a_reg  = '0;
    sel_b_reg  = '0;
    ld_imask   = 1'b0;
    imask_in   = 1'b0;
    ld_mode    = 1'b0;
    mode_in    = MODE_USER;
    vec_out    = '0;
    oe_vec     = 1'b0;
    ld_pc      = 1'b0;
    ack        = '0;
    if (en) begin
      if (state_q != IDLE) vec_out = vec;
      case (state_q)
        PUSH_PC: begin
          pre_dec_sp = 1'b1;
          wr         = 1'b1;
          oe_a_reg   = 1'b1;
          oe_b_reg   = 1'b1;
          sel_a_reg  = REG_PC;
          sel_b_reg  = REG_SP;
          ld_imask   = 1'b1;
          ld_mode    = 1'b1;
          mode_in    = MODE_SUPERVISOR;
        end
        PUSH_ST: begin
          pre_dec_sp = 1'b1;
          wr         = 1'b1;
          oe_a_reg   = 1'b1;
          oe_b_reg   = 1'b1;
          sel_a_reg  = REG_STATUS;
          sel_b_reg  = REG_SP;
        end
        LOAD_VEC: begin
          oe_vec = 1'b1;
          ld_pc  = 1'b1;
          if (cause_q == CAUSE_HW) ack = NUM_IRQ'(1) << id_q;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: a fixed-priority level instance (u_fix) and a
// round-robin instance with channel 0 edge-captured (u_rr) share the inputs.
// Each vector drives inputs after the falling edge and compares a snapshot of
// one instance's outputs against a value built from the expected state.
module tb_irq_seq;
  import irq_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mask_wr, imask, start, swint, except;
  logic [7:0] irq, mask_in;

  typedef struct packed {
    logic        busy, done, hwp;
    logic [8:0]  strb;  // pre_dec_sp,wr,oe_a,oe_b,ld_imask,imask_in,ld_mode,oe_vec,ld_pc
    logic [3:0]  sa, sb;
    logic [1:0]  mode;
    logic [31:0] vec;
    logic [7:0]  ack;
    logic [4:0]  id;
  } obs_t;

  logic f_hwp, f_busy, f_done, f_pre, f_wr, f_oea, f_oeb, f_lim, f_imi, f_lmd, f_oev, f_ldpc;
  logic r_hwp, r_busy, r_done, r_pre, r_wr, r_oea, r_oeb, r_lim, r_imi, r_lmd, r_oev, r_ldpc;
  logic [3:0]  f_sa, f_sb, r_sa, r_sb;
  cpu_mode_e   f_mode, r_mode;
  logic [31:0] f_vec, r_vec;
  logic [7:0]  f_ack, r_ack;
  logic [4:0]  f_id, r_id;
  obs_t fo, ro;

  assign fo = {f_busy, f_done, f_hwp, f_pre, f_wr, f_oea, f_oeb, f_lim, f_imi, f_lmd, f_oev, f_ldpc,
               f_sa, f_sb, f_mode, f_vec, f_ack, f_id};
  assign ro = {r_busy, r_done, r_hwp, r_pre, r_wr, r_oea, r_oeb, r_lim, r_imi, r_lmd, r_oev, r_ldpc,
               r_sa, r_sb, r_mode, r_vec, r_ack, r_id};

  irq_seq #(.NUM_IRQ(8), .EDGE_MASK(32'h0), .RR_EN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .irq(irq), .mask_wr(mask_wr), .mask_in(mask_in),
    .imask(imask), .start(start), .swint(swint), .except(except),
    .hw_pending(f_hwp), .busy(f_busy), .done(f_done), .pre_dec_sp(f_pre), .wr(f_wr),
    .oe_a_reg(f_oea), .oe_b_reg(f_oeb), .sel_a_reg(f_sa), .sel_b_reg(f_sb),
    .ld_imask(f_lim), .imask_in(f_imi), .ld_mode(f_lmd), .mode_in(f_mode),
    .vec_out(f_vec), .oe_vec(f_oev), .ld_pc(f_ldpc), .ack(f_ack), .irq_id(f_id));

  irq_seq #(.NUM_IRQ(8), .EDGE_MASK(32'h1), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .irq(irq), .mask_wr(mask_wr), .mask_in(mask_in),
    .imask(imask), .start(start), .swint(swint), .except(except),
    .hw_pending(r_hwp), .busy(r_busy), .done(r_done), .pre_dec_sp(r_pre), .wr(r_wr),
    .oe_a_reg(r_oea), .oe_b_reg(r_oeb), .sel_a_reg(r_sa), .sel_b_reg(r_sb),
    .ld_imask(r_lim), .imask_in(r_imi), .ld_mode(r_lmd), .mode_in(r_mode),
    .vec_out(r_vec), .oe_vec(r_oev), .ld_pc(r_ldpc), .ack(r_ack), .irq_id(r_id));

  // en irq mw mi im st sw ex | dut ph(0 idle/frozen,1 push_pc,2 push_st,3 load_vec,4 done) busy hwp vec ack id
  typedef struct {
    logic en; logic [7:0] irq; logic mw; logic [7:0] mi; logic im, st, sw, ex;
    bit dut; int ph; logic busy, hwp; logic [31:0] vec; logic [7:0] ack; logic [4:0] id;
  } vec_t;

  int nvec = 0, nerr = 0;

  function automatic obs_t mk(input int ph, input logic busy, input logic hwp,
                              input logic [31:0] vec, input logic [7:0] ack, input logic [4:0] id);
    obs_t o;
    o = '0;
    o.busy = busy; o.hwp = hwp; o.vec = vec; o.ack = ack; o.id = id;
    o.done = (ph == 4);
    case (ph)
      1: begin o.strb = 9'b111110100; o.sa = REG_PC;     o.sb = REG_SP; o.mode = MODE_SUPERVISOR; end
      2: begin o.strb = 9'b111100000; o.sa = REG_STATUS; o.sb = REG_SP; end
      3: o.strb = 9'b000000011;
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string nm, input int i, input bit dut, input obs_t want);
    obs_t got;
    got = dut ? ro : fo;
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s[%0d] dut%0d: got busy=%b done=%b hwp=%b strb=%b sel=%h/%h mode=%0d vec=%h ack=%h id=%0d; want busy=%b done=%b hwp=%b strb=%b sel=%h/%h mode=%0d vec=%h ack=%h id=%0d",
               nm, i, dut, got.busy, got.done, got.hwp, got.strb, got.sa, got.sb, got.mode, got.vec, got.ack, got.id,
               want.busy, want.done, want.hwp, want.strb, want.sa, want.sb, want.mode, want.vec, want.ack, want.id);
    end
  endtask

  task automatic apply(input string nm, input int i, input vec_t v);
    @(negedge clk);
    en = v.en; irq = v.irq; mask_wr = v.mw; mask_in = v.mi;
    imask = v.im; start = v.st; swint = v.sw; except = v.ex;
    #1 check(nm, i, v.dut, mk(v.ph, v.busy, v.hwp, v.vec, v.ack, v.id));
  endtask

  task automatic do_reset(input logic [7:0] irq_v);
    @(negedge clk);
    irq = irq_v; mask_wr = 1'b0; start = 1'b0; swint = 1'b0; except = 1'b0; en = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[33];
  vec_t seq[$];

  initial begin
    tbl = '{
      '{1, 8'hFF, 1, 8'hFF, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h13, 8'h08, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 1, 32'h13, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 1, 1, 1,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h03, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h03, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h03, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 1, 32'h03, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 1, 1, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 1,  0, 1, 1, 1, 32'h02, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h02, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h02, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 1, 32'h02, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'h00, 1, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h13, 8'h00, 5'd3},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 0, 32'h13, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 0, 32'h13, 8'h08, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 0, 32'h13, 8'h00, 5'd3},
      '{1, 8'h28, 1, 8'hFF, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 1, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h16, 8'h00, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h16, 8'h00, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h16, 8'h40, 5'd3},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 1, 32'h16, 8'h00, 5'd6},
      '{1, 8'hC0, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd6}
    };

    rst_n = 1'b0; en = 1'b1; irq = 8'hFF; mask_wr = 1'b0; mask_in = 8'h00;
    imask = 1'b0; start = 1'b0; swint = 1'b0; except = 1'b0;
    #12;
    check("reset", 0, 0, mk(0, 0, 0, 32'h0, 8'h00, 5'd0));
    check("reset", 1, 1, mk(0, 0, 0, 32'h0, 8'h00, 5'd0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 33; i++) apply("fixed", i, tbl[i]);

    // en dropped for three cycles while in PUSH_ST
    seq = '{
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd6},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd6},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h13, 8'h00, 5'd6},
      '{0, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 1, 1, 32'h00, 8'h00, 5'd6},
      '{0, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 1, 1, 32'h00, 8'h00, 5'd6},
      '{0, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 1, 1, 32'h00, 8'h00, 5'd6},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h13, 8'h00, 5'd6},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h13, 8'h08, 5'd6},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 4, 1, 1, 32'h13, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd3}
    };
    foreach (seq[i]) apply("en_hold", i, seq[i]);

    // round-robin: ids 3, 5, 3 with irq held at 0010_1000
    do_reset(8'h28);
    seq = '{
      '{1, 8'h28, 1, 8'hFF, 1, 0, 0, 0,  1, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h13, 8'h08, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 1, 32'h13, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h15, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h15, 8'h00, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h15, 8'h20, 5'd3},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 1, 32'h15, 8'h00, 5'd5},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd5},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h13, 8'h00, 5'd5},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h13, 8'h00, 5'd5},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h13, 8'h08, 5'd5},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 1, 32'h13, 8'h00, 5'd3}
    };
    foreach (seq[i]) apply("rr", i, seq[i]);

    // edge channel 0: one-cycle pulse latched, ack clears it; then a new
    // edge coincident with ack keeps it pending for a second entry
    do_reset(8'h00);
    seq = '{
      '{1, 8'h00, 1, 8'hFF, 1, 0, 0, 0,  1, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h01, 0, 8'h00, 1, 0, 0, 0,  1, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h10, 8'h01, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 0, 32'h10, 8'h00, 5'd0},
      '{1, 8'h01, 0, 8'h00, 1, 0, 0, 0,  1, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h01, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h10, 8'h01, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0,  1, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 2, 1, 1, 32'h10, 8'h00, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 3, 1, 1, 32'h10, 8'h01, 5'd0},
      '{1, 8'h00, 0, 8'h00, 1, 0, 0, 0,  1, 4, 1, 0, 32'h10, 8'h00, 5'd0}
    };
    foreach (seq[i]) apply("edge", i, seq[i]);

    // reset asserted during LOAD_VEC on the fixed instance
    seq = '{
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 1, 0, 0,  0, 0, 0, 1, 32'h00, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 2, 1, 1, 32'h13, 8'h00, 5'd0},
      '{1, 8'h28, 0, 8'h00, 1, 0, 0, 0,  0, 3, 1, 1, 32'h13, 8'h08, 5'd0}
    };
    foreach (seq[i]) apply("rst_mid", i, seq[i]);
    rst_n = 1'b0;
    #1 check("rst_mid", 5, 0, mk(0, 0, 0, 32'h0, 8'h00, 5'd0));
    @(negedge clk);
    rst_n = 1'b1;
    apply("rst_mid", 6, '{1, 8'hFF, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd0});
    apply("rst_mid", 7, '{1, 8'hFF, 0, 8'h00, 1, 0, 0, 0,  0, 0, 0, 0, 32'h00, 8'h00, 5'd0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
